// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ioctl-to-SDRAM download buffer.
package jtframe_dwnld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } dwnld_state_t;

    // Active-low byte enables: bit0 is the low byte of the 16-bit word.
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    // Widest byte address an entry can carry; narrower AW is zero-extended.
    localparam int ENTRY_AW = 32;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          data;
    } dwnld_entry_t;

    function automatic logic [1:0] byte_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO with occupancy count and a registered almost-full
// flag that rises once only one free slot remains.
module jtframe_dwnld_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk_sys,
    input  logic                   RESET,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nx;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        if (do_push && !do_pop)
            count_nx = count + 1'b1;
        else if (!do_push && do_pop)
            count_nx = count - 1'b1;
    end

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nx;
            almost_full <= (count_nx >= CW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jtframe_dwnld_buf.sv
// Buffers HPS ioctl byte writes and replays them as masked SDRAM word writes.
// Optional header skipping is enabled with JTFRAME_DWNLD_HEADER_EN.
module jtframe_dwnld_buf #(
    parameter int DEPTH      = 4,
    parameter int AW         = 22,
    parameter int HEADER_LEN = 0
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic          downloading,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic          ioctl_wait,
    output logic          prog_we,
    output logic [AW-1:0] prog_addr,
    output logic [7:0]    prog_data,
    output logic [1:0]    prog_mask,
    input  logic          prog_rdy,
    output logic          dwnld_done,
    output logic [AW-1:0] byte_cnt,
    output logic          overflow
);
    import jtframe_dwnld_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef JTFRAME_DWNLD_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam logic [AW-1:0] HDR_OFS = HDR_EN ? AW'(HEADER_LEN) : '0;

    dwnld_state_t  st;
    dwnld_entry_t  wr_entry, head;
    logic [AW-1:0] push_addr;
    logic          skip, dl_last, dl_rise, seen_dl;
    logic          push, pop, drop;
    logic          f_full, f_empty;
    logic [CW-1:0] f_count;

    // The subtraction borrow flags header bytes (addr < HDR_OFS) without a compare.
    assign {skip, push_addr} = {1'b0, ioctl_addr} - {1'b0, HDR_OFS};

    assign dl_rise = downloading && !dl_last;
    assign push    = ioctl_wr && downloading && !skip;
    assign drop    = push && f_full;
    assign pop     = (st == ST_WRITE) && prog_rdy;

    assign wr_entry.addr = ENTRY_AW'(push_addr);
    assign wr_entry.data = ioctl_data;

    jtframe_dwnld_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(dwnld_entry_t))
    ) u_fifo (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .push        (push),
        .pop         (pop),
        .din         (wr_entry),
        .dout        (head),
        .full        (f_full),
        .empty       (f_empty),
        .count       (f_count),
        .almost_full (ioctl_wait)
    );

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            st         <= ST_IDLE;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            prog_mask  <= MASK_NONE;
            dwnld_done <= 1'b0;
            byte_cnt   <= '0;
            overflow   <= 1'b0;
            dl_last    <= 1'b0;
            seen_dl    <= 1'b0;
        end else begin
            dl_last    <= downloading;
            dwnld_done <= 1'b0;
            if (downloading) seen_dl <= 1'b1;
            if (dl_rise)     overflow <= 1'b0;
            if (drop)        overflow <= 1'b1;
            byte_cnt <= (dl_rise ? '0 : byte_cnt) + AW'(pop);
            case (st)
                ST_IDLE: begin
                    if (!f_empty) begin
                        prog_addr <= AW'(head.addr >> 1);
                        prog_data <= head.data;
                        prog_mask <= byte_mask(head.addr[0]);
                        prog_we   <= 1'b1;
                        st        <= ST_WRITE;
                    end else if (!downloading && seen_dl) begin
                        // Queue drained after the download ended: report once.
                        dwnld_done <= 1'b1;
                        prog_mask  <= MASK_NONE;
                        seen_dl    <= 1'b0;
                        st         <= ST_FINISH;
                    end
                end
                ST_WRITE: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        st      <= ST_IDLE;
                    end
                end
                ST_FINISH: st <= ST_IDLE;
                default:   st <= ST_IDLE;
            endcase
        end
    end

    a_count_range: assert property (@(posedge clk_sys) disable iff (RESET)
        f_count <= CW'(DEPTH));

    a_we_in_write: assert property (@(posedge clk_sys) disable iff (RESET)
        prog_we == (st == ST_WRITE));

endmodule

// File: tb/tb_jtframe_dwnld_buf.sv
// Self-checking bench for jtframe_dwnld_buf: directed scenarios plus a
// randomized stream checked against an address-arithmetic reference model.
`timescale 1ns/1ps
module tb_jtframe_dwnld_buf;
    localparam int DEPTH      = 4;
    localparam int AW         = 22;
    localparam int HEADER_LEN = 16;
`ifdef JTFRAME_DWNLD_HEADER_EN
    localparam int HDR_SKIP = HEADER_LEN;
`else
    localparam int HDR_SKIP = 0;
`endif

    logic          clk_sys = 1'b0;
    logic          RESET = 1'b1;
    logic          downloading = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_data = '0;
    logic          prog_rdy = 1'b0;
    logic          ioctl_wait, prog_we, dwnld_done, overflow;
    logic [AW-1:0] prog_addr, byte_cnt;
    logic [7:0]    prog_data;
    logic [1:0]    prog_mask;

    jtframe_dwnld_buf #(.DEPTH(DEPTH), .AW(AW), .HEADER_LEN(HEADER_LEN)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .downloading (downloading),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wait  (ioctl_wait),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_rdy    (prog_rdy),
        .dwnld_done  (dwnld_done),
        .byte_cnt    (byte_cnt),
        .overflow    (overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    int unsigned cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int unsigned pop_edge[$];
    int unsigned done_edge[$];

    // An accepted write is prog_we && prog_rdy just before a rising edge.
    always @(negedge clk_sys) begin
        if (!RESET && prog_we && prog_rdy) begin
            got_q.push_back({prog_addr, prog_data, prog_mask});
            pop_edge.push_back(cyc + 1);
        end
        if (dwnld_done) done_edge.push_back(cyc);
    end

    // Reference: SDRAM word = rebased byte address / 2, odd byte enables the high lane.
    function automatic logic [31:0] exp_write(input int unsigned a, input logic [7:0] d);
        int unsigned eff;
        logic [AW-1:0] word;
        logic [1:0] mask;
        eff  = a - HDR_SKIP;
        word = AW'(eff / 2);
        mask = (eff % 2 == 1) ? 2'b01 : 2'b10;
        return {word, d, mask};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic strobe(input int unsigned a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = AW'(a);
        ioctl_data = d;
        tick(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_wr    = 1'b0;
        prog_rdy    = 1'b0;
        downloading = 1'b0;
        tick(4);
        downloading = 1'b1;
        tick(2);
        exp_q.delete();
        got_q.delete();
        pop_edge.delete();
        done_edge.delete();
    endtask

    task automatic compare_queues(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (got_q.size() != exp_q.size() || bad != 0)
            $display("FAIL %s: got %0d writes (%0d wrong) want %0d writes", name, got_q.size(), bad, exp_q.size());
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b1;
        tick(3);
        n_checks++;
        if ({ioctl_wait, prog_we, dwnld_done, overflow} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {ioctl_wait, prog_we, dwnld_done, overflow});
        else n_pass++;
        n_checks++;
        if ({prog_addr, prog_data, prog_mask} !== {{AW{1'b0}}, 8'h00, 2'b11})
            $display("FAIL reset_prog: got %h/%h/%b want 0/0/11", prog_addr, prog_data, prog_mask);
        else n_pass++;
        n_checks++;
        if (byte_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", byte_cnt);
        else n_pass++;
        RESET = 1'b0;
        tick(2);
    endtask

    task automatic test_not_downloading();
        downloading = 1'b0;
        prog_rdy = 1'b1;
        tick(2);
        got_q.delete();
        for (int i = 0; i < 3; i++) strobe(HDR_SKIP + i, 8'h10 + 8'(i));
        tick(10);
        n_checks++;
        if (got_q.size() != 0) $display("FAIL ignore_idle: got %0d writes want 0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_single_byte();
        logic [31:0] e;
        start_dl();
        prog_rdy = 1'b1;
        e = exp_write(HDR_SKIP + 5, 8'hA5);
        strobe(HDR_SKIP + 5, 8'hA5);
        n_checks++;
        if (prog_we !== 1'b0) $display("FAIL single_early: got we=%b want 0", prog_we);
        else n_pass++;
        tick(1);
        n_checks++;
        if ({prog_we, prog_addr, prog_data, prog_mask} !== {1'b1, e})
            $display("FAIL single_write: got %b/%h/%h/%b want 1/%h", prog_we, prog_addr, prog_data, prog_mask, e);
        else n_pass++;
        tick(1);
        n_checks++;
        if (byte_cnt !== AW'(1) || prog_we !== 1'b0)
            $display("FAIL single_cnt: got cnt=%0d we=%b want 1/0", byte_cnt, prog_we);
        else n_pass++;
        prog_rdy = 1'b0;
    endtask

    task automatic test_stall_overflow();
        start_dl();
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(exp_write(HDR_SKIP + 2*k, 8'h30 + 8'(k)));
            strobe(HDR_SKIP + 2*k, 8'h30 + 8'(k));
            n_checks++;
            if (ioctl_wait !== (k >= 3))
                $display("FAIL stall_wait_%0d: got %b want %b", k, ioctl_wait, (k >= 3));
            else n_pass++;
        end
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL stall_no_ovf: got %b want 0", overflow);
        else n_pass++;
        strobe(HDR_SKIP + 99, 8'hEE);
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL stall_ovf: got %b want 1", overflow);
        else n_pass++;
        prog_rdy = 1'b1;
        for (int i = 0; i < 40 && byte_cnt != AW'(4); i++) tick(1);
        tick(4);
        n_checks++;
        if (byte_cnt !== AW'(4) || overflow !== 1'b1)
            $display("FAIL stall_drain: got cnt=%0d ovf=%b want 4/1", byte_cnt, overflow);
        else n_pass++;
        compare_queues("stall_data");
        prog_rdy = 1'b0;
    endtask

    task automatic test_held_request();
        logic [32:0] snap;
        int changes;
        start_dl();
        exp_q.push_back(exp_write(HDR_SKIP + 7, 8'h5C));
        strobe(HDR_SKIP + 7, 8'h5C);
        for (int i = 0; i < 10 && !prog_we; i++) tick(1);
        snap = {prog_we, prog_addr, prog_data, prog_mask};
        n_checks++;
        if (snap !== {1'b1, exp_q[0]}) $display("FAIL held_start: got %h want %h", snap, {1'b1, exp_q[0]});
        else n_pass++;
        changes = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if ({prog_we, prog_addr, prog_data, prog_mask} !== snap) changes++;
        end
        n_checks++;
        if (changes != 0) $display("FAIL held_stable: got %0d changed cycles want 0", changes);
        else n_pass++;
        prog_rdy = 1'b1;
        tick(1);
        prog_rdy = 1'b0;
        tick(6);
        n_checks++;
        if (byte_cnt !== AW'(1) || prog_we !== 1'b0)
            $display("FAIL held_pop: got cnt=%0d we=%b want 1/0", byte_cnt, prog_we);
        else n_pass++;
        compare_queues("held_data");
    endtask

    task automatic test_end_of_download();
        start_dl();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(exp_write(HDR_SKIP + 11 + k, 8'h70 + 8'(k)));
            strobe(HDR_SKIP + 11 + k, 8'h70 + 8'(k));
        end
        downloading = 1'b0;
        for (int i = 0; i < 60; i++) begin
            prog_rdy = (i % 5 == 4);
            tick(1);
        end
        prog_rdy = 1'b0;
        n_checks++;
        if (pop_edge.size() != 3 || done_edge.size() != 1)
            $display("FAIL eod_counts: got pops=%0d dones=%0d want 3/1", pop_edge.size(), done_edge.size());
        else n_pass++;
        n_checks++;
        if (pop_edge.size() == 3 && done_edge.size() == 1 && done_edge[0] == pop_edge[2] + 1) n_pass++;
        else $display("FAIL eod_timing: got done edge %0d want last pop edge + 1 (pops=%0d dones=%0d)",
                      (done_edge.size() > 0) ? done_edge[0] : 0, pop_edge.size(), done_edge.size());
        compare_queues("eod_data");
    endtask

    task automatic test_reset_mid_write();
        start_dl();
        strobe(HDR_SKIP + 1, 8'h11);
        strobe(HDR_SKIP + 2, 8'h22);
        for (int i = 0; i < 10 && !prog_we; i++) tick(1);
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if (prog_we !== 1'b0) $display("FAIL rst_async: got we=%b want 0", prog_we);
        else n_pass++;
        tick(2);
        RESET = 1'b0;
        got_q.delete();
        prog_rdy = 1'b1;
        tick(15);
        prog_rdy = 1'b0;
        n_checks++;
        if (got_q.size() != 0 || byte_cnt !== '0)
            $display("FAIL rst_flush: got %0d writes cnt=%0d want 0/0", got_q.size(), byte_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int sent, n;
        int unsigned a;
        logic [7:0] d;
        n = 50;
        sent = 0;
        start_dl();
        for (int i = 0; i < 3000 && !(sent == n && byte_cnt == AW'(n)); i++) begin
            prog_rdy = 1'($urandom_range(0, 1));
            if (sent < n && !ioctl_wait && $urandom_range(0, 2) != 0) begin
                a = HDR_SKIP + $urandom_range(0, 4095);
                d = 8'($urandom_range(0, 255));
                exp_q.push_back(exp_write(a, d));
                ioctl_wr = 1'b1;
                ioctl_addr = AW'(a);
                ioctl_data = d;
                sent++;
            end else ioctl_wr = 1'b0;
            tick(1);
        end
        ioctl_wr = 1'b0;
        prog_rdy = 1'b0;
        tick(4);
        n_checks++;
        if (byte_cnt !== AW'(n) || overflow !== 1'b0)
            $display("FAIL rand_cnt: got cnt=%0d ovf=%b want %0d/0", byte_cnt, overflow, n);
        else n_pass++;
        compare_queues("rand_data");
    endtask

    task automatic test_header();
        start_dl();
        prog_rdy = 1'b1;
        for (int a = 0; a < 20; a++) begin
            for (int w = 0; w < 20 && ioctl_wait; w++) tick(1);
            if (a >= HDR_SKIP) exp_q.push_back(exp_write(a, 8'h40 + 8'(a)));
            strobe(a, 8'h40 + 8'(a));
        end
        tick(20);
        prog_rdy = 1'b0;
        n_checks++;
        if (byte_cnt !== AW'(20 - HDR_SKIP))
            $display("FAIL hdr_cnt: got %0d want %0d", byte_cnt, 20 - HDR_SKIP);
        else n_pass++;
        compare_queues("hdr_data");
    endtask

    initial begin
        test_reset();
        test_not_downloading();
        test_single_byte();
        test_stall_overflow();
        test_held_request();
        test_end_of_download();
        test_reset_mid_write();
        test_random();
        test_header();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
